// File: rtl/axi4s_packet_fifo.sv
// axi4s_packet_fifo
// Store-and-forward AXI4-Stream FIFO placed in front of one round-robin mux
// input. Egress tvalid is raised only once a complete tlast-terminated packet
// is stored, so a granted packet drains without bubbles. A packet longer than
// the FIFO depth would otherwise deadlock the stage. In that case the FIFO
// releases it in cut-through mode.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   axi4s_i_*       ingress stream (tready out; tvalid/tlast/tdata in)
//   axi4s_o_*       egress stream (tready in; tvalid/tlast/tdata out)
//   fill_level      entries currently stored
//   packet_count    complete (tlast-terminated) packets currently stored
//   cut_through     high while an oversized packet is being force-released
module axi4s_packet_fifo #(
    parameter int tdata_width_p = 3,
    parameter int addr_width_p  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         axi4s_i_tready,
    input  logic                         axi4s_i_tvalid,
    input  logic                         axi4s_i_tlast,
    input  logic [tdata_width_p*8-1:0]   axi4s_i_tdata,
    input  logic                         axi4s_o_tready,
    output logic                         axi4s_o_tvalid,
    output logic                         axi4s_o_tlast,
    output logic [tdata_width_p*8-1:0]   axi4s_o_tdata,
    output logic [addr_width_p:0]        fill_level,
    output logic [addr_width_p:0]        packet_count,
    output logic                         cut_through
);

    localparam int DW    = tdata_width_p * 8;
    localparam int DEPTH = 1 << addr_width_p;
    localparam logic [addr_width_p:0] DEPTH_L = (addr_width_p + 1)'(DEPTH);
    localparam logic [addr_width_p:0] ONE_L   = (addr_width_p + 1)'(1);

    // Each entry holds {tlast, tdata}.
    logic [DW:0]             r_mem [DEPTH];
    logic [addr_width_p:0]   r_wr_ptr;
    logic [addr_width_p:0]   r_rd_ptr;
    logic [addr_width_p:0]   r_pkt_cnt;
    logic                    r_cut;

    logic [addr_width_p:0]   w_fill;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_pkt_inc;
    logic                    w_pkt_dec;
    logic [addr_width_p:0]   w_pkt_next;

    // The pointers carry one extra bit. This keeps full and empty distinct
    // without a separate flag.
    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_fill == DEPTH_L);
    assign w_empty = (w_fill == '0);

    assign axi4s_i_tready = !w_full && !rst;
    assign axi4s_o_tvalid = !w_empty && ((r_pkt_cnt != '0) || r_cut);

    assign w_wr = axi4s_i_tvalid && axi4s_i_tready;
    assign w_rd = axi4s_o_tvalid && axi4s_o_tready;

    // The memory is read asynchronously, so the head entry is presented
    // directly with no output register.
    assign {axi4s_o_tlast, axi4s_o_tdata} = r_mem[r_rd_ptr[addr_width_p-1:0]];

    assign w_pkt_inc = w_wr && axi4s_i_tlast;
    assign w_pkt_dec = w_rd && axi4s_o_tlast;

    always_comb begin
        w_pkt_next = r_pkt_cnt;
        case ({w_pkt_inc, w_pkt_dec})
            2'b10:   w_pkt_next = r_pkt_cnt + ONE_L;
            2'b01:   w_pkt_next = r_pkt_cnt - ONE_L;
            default: w_pkt_next = r_pkt_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pkt_cnt <= '0;
            r_cut     <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + ONE_L;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ONE_L;
            end
            r_pkt_cnt <= w_pkt_next;
            // When the FIFO is full and holds no complete packet, no tlast
            // is stored yet. Set and clear therefore never coincide.
            if (w_rd && axi4s_o_tlast) begin
                r_cut <= 1'b0;
            end else if (w_full && (r_pkt_cnt == '0)) begin
                r_cut <= 1'b1;
            end
        end
    end

    // Stored data needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[addr_width_p-1:0]] <= {axi4s_i_tlast, axi4s_i_tdata};
        end
    end

    assign fill_level   = w_fill;
    assign packet_count = r_pkt_cnt;
    assign cut_through  = r_cut;

endmodule

// File: tb/tb_axi4s_packet_fifo.sv
module tb_axi4s_packet_fifo;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          axi4s_i_tready;
    logic          axi4s_i_tvalid = 1'b0;
    logic          axi4s_i_tlast  = 1'b0;
    logic [DW-1:0] axi4s_i_tdata  = '0;
    logic          axi4s_o_tready = 1'b0;
    logic          axi4s_o_tvalid;
    logic          axi4s_o_tlast;
    logic [DW-1:0] axi4s_o_tdata;
    logic [AW:0]   fill_level;
    logic [AW:0]   packet_count;
    logic          cut_through;

    axi4s_packet_fifo #(.tdata_width_p(3), .addr_width_p(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .axi4s_i_tready (axi4s_i_tready),
        .axi4s_i_tvalid (axi4s_i_tvalid),
        .axi4s_i_tlast  (axi4s_i_tlast),
        .axi4s_i_tdata  (axi4s_i_tdata),
        .axi4s_o_tready (axi4s_o_tready),
        .axi4s_o_tvalid (axi4s_o_tvalid),
        .axi4s_o_tlast  (axi4s_o_tlast),
        .axi4s_o_tdata  (axi4s_o_tdata),
        .fill_level     (fill_level),
        .packet_count   (packet_count),
        .cut_through    (cut_through)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the stored beats in arrival order, plus the
    // cut-through flag derived from the release rules.
    logic [DW:0] exp_q[$];
    logic        m_cut   = 1'b0;
    bit          mon_en  = 1'b0;
    bit          saw_cut = 1'b0;
    int          cut_fill = -1;
    int          cut_pkt  = -1;
    int          n_out    = 0;
    bit          hold_v   = 1'b0;
    logic [DW:0] hold_d   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. The beat is pushed to the scoreboard when it is accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int t = 0;
        bit acc = 1'b0;
        axi4s_i_tvalid = 1'b1;
        axi4s_i_tdata  = d;
        axi4s_i_tlast  = last;
        while (!acc && t < 2000) begin
            @(negedge clk);
            #1;
            if (axi4s_i_tready) begin
                acc = 1'b1;
                exp_q.push_back({last, d});
            end
            tick();
            t++;
        end
        axi4s_i_tvalid = 1'b0;
        axi4s_i_tlast  = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_beat: data 0x%0h never accepted (ready stuck low)", d);
        end
    endtask

    task automatic wait_empty(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s drain: %0d beats still expected, got none", name, exp_q.size());
        end
        @(negedge clk);
        chk({name, " fill_after_drain"}, 32'(fill_level), 32'd0);
        chk({name, " pkt_after_drain"}, 32'(packet_count), 32'd0);
    endtask

    // Monitor: checks status against the model every cycle, and pops and
    // compares every accepted egress beat.
    always @(negedge clk) begin
        int sz;
        int pk;
        bit popped_last;
        logic [DW:0] e;
        if (mon_en) begin
            sz = exp_q.size();
            pk = 0;
            foreach (exp_q[i]) if (exp_q[i][DW]) pk++;
            popped_last = 1'b0;
            chk("fill_level", 32'(fill_level), 32'(sz));
            chk("packet_count", 32'(packet_count), 32'(pk));
            chk("i_tready", 32'(axi4s_i_tready), 32'((sz < DEPTH) && !rst));
            chk("o_tvalid", 32'(axi4s_o_tvalid), 32'((sz > 0) && (pk > 0 || m_cut)));
            chk("cut_through", 32'(cut_through), 32'(m_cut));
            if (hold_v && !rst) begin
                chk("stable_tvalid", 32'(axi4s_o_tvalid), 32'd1);
                chk("stable_beat", 32'({axi4s_o_tlast, axi4s_o_tdata}), 32'(hold_d));
            end
            hold_v = axi4s_o_tvalid && !axi4s_o_tready && !rst;
            hold_d = {axi4s_o_tlast, axi4s_o_tdata};
            if (cut_through && !saw_cut) begin
                saw_cut  = 1'b1;
                cut_fill = int'(fill_level);
                cut_pkt  = int'(packet_count);
            end
            if (rst) begin
                exp_q.delete();
                m_cut = 1'b0;
            end else begin
                if (axi4s_o_tvalid && axi4s_o_tready) begin
                    if (sz == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL underflow: got beat 0x%0h expected none", axi4s_o_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        n_out++;
                        chk("out_beat", 32'({axi4s_o_tlast, axi4s_o_tdata}), 32'(e));
                        popped_last = e[DW];
                    end
                end
                if (popped_last) m_cut = 1'b0;
                else if (sz == DEPTH && pk == 0) m_cut = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit done;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst fill", 32'(fill_level), 32'd0);
        chk("rst pkt", 32'(packet_count), 32'd0);
        chk("rst cut", 32'(cut_through), 32'd0);
        chk("rst tvalid", 32'(axi4s_o_tvalid), 32'd0);
        chk("rst tready", 32'(axi4s_i_tready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst tready", 32'(axi4s_i_tready), 32'd1);
        tick();

        // Single packet, egress ready throughout
        axi4s_o_tready = 1'b1;
        for (int i = 1; i <= 4; i++) send_beat(DW'(i), i == 4);
        @(negedge clk);
        chk("t1 tvalid_after_last", 32'(axi4s_o_tvalid), 32'd1);
        chk("t1 first_beat", 32'(axi4s_o_tdata), 32'd1);
        chk("t1 pkt", 32'(packet_count), 32'd1);
        wait_empty("t1");
        tick();

        // Back-pressure: three 5-beat packets, then a 1-beat packet
        axi4s_o_tready = 1'b0;
        for (int p = 0; p < 3; p++)
            for (int b = 1; b <= 5; b++) send_beat(DW'(32'h100 + p * 16 + b), b == 5);
        @(negedge clk);
        chk("t2 fill15", 32'(fill_level), 32'd15);
        chk("t2 pkt3", 32'(packet_count), 32'd3);
        chk("t2 tready", 32'(axi4s_i_tready), 32'd1);
        tick();
        send_beat(DW'(32'h1FF), 1'b1);
        @(negedge clk);
        chk("t2 fill16", 32'(fill_level), 32'd16);
        chk("t2 tready_full", 32'(axi4s_i_tready), 32'd0);
        tick();
        axi4s_o_tready = 1'b1;
        wait_empty("t2");
        tick();

        // tlast written in the same cycle as the previous tlast is read
        axi4s_o_tready = 1'b0;
        send_beat(DW'(32'hA1), 1'b0);
        send_beat(DW'(32'hA2), 1'b1);
        axi4s_o_tready = 1'b1;
        tick();
        send_beat(DW'(32'hB1), 1'b1);
        @(negedge clk);
        chk("t3 pkt_unchanged", 32'(packet_count), 32'd1);
        chk("t3 fill", 32'(fill_level), 32'd1);
        wait_empty("t3");
        tick();

        // Oversized 20-beat packet is released by cut-through
        saw_cut = 1'b0;
        for (int i = 1; i <= 20; i++) send_beat(DW'(32'h200 + i), i == 20);
        wait_empty("t4");
        chk("t4 saw_cut", 32'(saw_cut), 32'd1);
        chk("t4 cut_fill", 32'(cut_fill), 32'd16);
        chk("t4 cut_pkt", 32'(cut_pkt), 32'd0);
        chk("t4 cut_cleared", 32'(cut_through), 32'd0);
        tick();

        // Reset in the middle of a packet discards the partial packet
        for (int i = 1; i <= 3; i++) send_beat(DW'(32'h300 + i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 fill", 32'(fill_level), 32'd0);
        chk("t5 pkt", 32'(packet_count), 32'd0);
        chk("t5 tvalid", 32'(axi4s_o_tvalid), 32'd0);
        tick();
        send_beat(DW'(32'h311), 1'b0);
        send_beat(DW'(32'h312), 1'b1);
        wait_empty("t5");
        tick();

        // Pointer wrap: 40 single-beat packets with random egress ready
        base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 1; i <= 40; i++) begin
                    if ($urandom_range(0, 2) == 0) tick();
                    send_beat(DW'(i), 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    axi4s_o_tready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        axi4s_o_tready = 1'b1;
        wait_empty("t6");
        chk("t6 beats_out", 32'(n_out - base), 32'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
